// File: rtl/edge_event_sequencer.sv
// Walks an N_STEPS table of edge/event wait conditions, advancing one step per match.
// Supports one-shot or looping runs with an optional per-step timeout.
module edge_event_sequencer #(
    parameter int N_SIG   = 2,
    parameter int N_EVT   = 1,
    parameter int N_STEPS = 4,
    parameter int TMO_W   = 16,
    parameter int CNT_W   = 8,
    localparam int STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SIG-1:0]           sig,
    input  logic [N_EVT-1:0]           evt,
    input  logic [N_STEPS*N_SIG-1:0]   pos_mask,
    input  logic [N_STEPS*N_SIG-1:0]   neg_mask,
    input  logic [N_STEPS*N_EVT-1:0]   evt_mask,
    input  logic                       loop_en,
    input  logic [TMO_W-1:0]           tmo_cycles,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic [STEP_W-1:0]          step_idx,
    output logic                       step_hit,
    output logic [N_SIG-1:0]           hit_pos,
    output logic [N_SIG-1:0]           hit_neg,
    output logic [N_EVT-1:0]           hit_evt,
    output logic                       done,
    output logic                       timeout,
    output logic [CNT_W-1:0]           loop_count
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state, state_n;
    logic [N_SIG-1:0]   prev;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
    logic [STEP_W-1:0]  step_n;
    logic [CNT_W-1:0]   loop_n;
    logic               step_hit_n, done_n, timeout_n;
    logic [N_SIG-1:0]   hit_pos_n, hit_neg_n;
    logic [N_EVT-1:0]   hit_evt_n;

    logic [N_SIG-1:0]   pe, ne, m_pos, m_neg;
    logic [N_EVT-1:0]   m_evt;
    logic               match, last, tmo_hit;
    int unsigned        sig_base, evt_base;

    always_comb begin
        pe       = sig & ~prev;
        ne       = ~sig & prev;
        sig_base = int'(step_idx) * N_SIG;
        evt_base = int'(step_idx) * N_EVT;
        m_pos    = pe  & pos_mask[sig_base +: N_SIG];
        m_neg    = ne  & neg_mask[sig_base +: N_SIG];
        m_evt    = evt & evt_mask[evt_base +: N_EVT];
        match    = (|m_pos) | (|m_neg) | (|m_evt);
        last     = (step_idx == STEP_W'(N_STEPS - 1));
        tmo_hit  = (tmo_cycles != '0) && (tmo_cnt == tmo_cycles - TMO_W'(1));
    end

    always_comb begin
        state_n    = state;
        step_n     = step_idx;
        tmo_cnt_n  = tmo_cnt;
        loop_n     = loop_count;
        step_hit_n = 1'b0;
        done_n     = 1'b0;
        timeout_n  = 1'b0;
        hit_pos_n  = '0;
        hit_neg_n  = '0;
        hit_evt_n  = '0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n   = WAIT;
                    step_n    = '0;
                    tmo_cnt_n = '0;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_n = IDLE;
                    step_n  = '0;
                end else if (match) begin
                    step_hit_n = 1'b1;
                    hit_pos_n  = m_pos;
                    hit_neg_n  = m_neg;
                    hit_evt_n  = m_evt;
                    tmo_cnt_n  = '0;
                    if (!last) begin
                        step_n = step_idx + STEP_W'(1);
                    end else if (loop_en) begin
                        step_n = '0;
                        loop_n = loop_count + CNT_W'(1);
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tmo_hit) begin
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // prev tracks sig even during reset so no edge appears on release
    always_ff @(posedge clk) begin
        prev <= sig;
        if (rst) begin
            state      <= IDLE;
            step_idx   <= '0;
            tmo_cnt    <= '0;
            loop_count <= '0;
            step_hit   <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            hit_pos    <= '0;
            hit_neg    <= '0;
            hit_evt    <= '0;
        end else begin
            state      <= state_n;
            step_idx   <= step_n;
            tmo_cnt    <= tmo_cnt_n;
            loop_count <= loop_n;
            step_hit   <= step_hit_n;
            done       <= done_n;
            timeout    <= timeout_n;
            hit_pos    <= hit_pos_n;
            hit_neg    <= hit_neg_n;
            hit_evt    <= hit_evt_n;
        end
    end

    assign busy = (state == WAIT);

endmodule
